sar_search: RTL and testbench

Successive-approximation search controller for W-bit unsigned values. It drives a trial value into an external magnitude comparator and reads back its greater and equal flags. It then resolves the comparator's hidden operand, the target, MSB first, one bit per clock, and stops early on an exact match. It is the initiator that pairs with our ripple magnitude comparator: trial connects to comparator input a, the target connects to input b, and g_in/e_in come back from its g/e outputs.

---
 rtl/sar_search.sv | 116 +++++++++++
 tb/tb_sar_search.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sar_search.sv
`default_nettype none
// ============================================================================
// Module   : sar_search
// Purpose  : Successive-approximation search controller. Resolves the hidden
//            operand of an external magnitude comparator MSB first.
// Revision : 1.0 - initial release
// ============================================================================
module sar_search #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic         g_in,
  input  logic         e_in,
  output logic [W-1:0] trial,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         exact
);

  localparam int                IDXW       = (W > 2) ? $clog2(W) : 1;
  localparam logic [IDXW-1:0]   c_IDX_MSB  = IDXW'(W - 1);
  localparam logic [IDXW-1:0]   c_IDX_ONE  = IDXW'(1);
  localparam logic [IDXW-1:0]   c_IDX_ZERO = '0;
  localparam logic [W-1:0]      c_TRIAL0   = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SRCH = 2'd1,
    S_CHK  = 2'd2
  } state_t;

  state_t            r_state, w_state;
  logic [IDXW-1:0]   r_idx,   w_idx;
  logic [W-1:0]      r_trial, w_trial;
  logic [W-1:0]      r_result, w_result;
  logic              r_exact, w_exact;
  logic              r_done,  w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= c_IDX_MSB;
      r_trial  <= '0;
      r_result <= '0;
      r_exact  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_idx    <= w_idx;
      r_trial  <= w_trial;
      r_result <= w_result;
      r_exact  <= w_exact;
      r_done   <= w_done;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_idx    = r_idx;
    w_trial  = r_trial;
    w_result = r_result;
    w_exact  = r_exact;
    w_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state = S_SRCH;
          w_trial = c_TRIAL0;
          w_idx   = c_IDX_MSB;
        end
      end
      S_SRCH: begin
        if (abort) begin
          w_state = S_IDLE;
        end else if (e_in) begin
          w_result = r_trial;
          w_exact  = 1'b1;
          w_done   = 1'b1;
          w_state  = S_IDLE;
        end else begin
          // Keep the tentative bit only if the trial was not above the target.
          w_trial[r_idx] = ~g_in;
          if (r_idx != c_IDX_ZERO) begin
            w_trial[r_idx - c_IDX_ONE] = 1'b1;
            w_idx = r_idx - c_IDX_ONE;
          end else begin
            w_state = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (abort) begin
          w_state = S_IDLE;
        end else begin
          w_result = r_trial;
          w_exact  = e_in;
          w_done   = 1'b1;
          w_state  = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign trial  = r_trial;
  assign result = r_result;
  assign exact  = r_exact;
  assign done   = r_done;
  assign busy   = (r_state == S_SRCH) || (r_state == S_CHK);

endmodule
`default_nettype wire

// File: tb/tb_sar_search.sv
`default_nettype none
// Testbench for sar_search: ideal/tied comparator model, scoreboard of
// expected {exact,result} pairs popped on every done pulse.
module tb_sar_search;

  localparam int W = 6;

  logic         clk, rst_n, start, abort;
  logic         g_in, e_in;
  logic [W-1:0] trial, result;
  logic         busy, done, exact;

  logic [W-1:0] target;
  logic         tied;

  int           n_total, n_bad;
  logic [W:0]   sb[$];
  int           tr_q[$];
  int           exp_q[$];
  logic         prev_done;

  sar_search #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .g_in  (g_in),
    .e_in  (e_in),
    .trial (trial),
    .busy  (busy),
    .done  (done),
    .result(result),
    .exact (exact)
  );

  // Comparator model: trial on input a, target on input b.
  assign g_in = tied ? 1'b0 : (trial > target);
  assign e_in = tied ? 1'b0 : (trial == target);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, "_len"}, tr_q.size(), exp_q.size());
    for (int i = 0; i < tr_q.size() && i < exp_q.size(); i++)
      chk({tag, "_step"}, tr_q[i], exp_q[i]);
  endtask

  // One search; records the trial seen in every busy cycle and the
  // number of edges after the start edge until done appears.
  task automatic run_one(input logic [W-1:0] tgt, input logic tie,
                         input logic [W-1:0] exp_res, input logic exp_ex,
                         output int lat);
    target = tgt;
    tied   = tie;
    tr_q.delete();
    sb.push_back({exp_ex, exp_res});
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (busy) tr_q.push_back(int'(trial));
      if (done) begin
        lat = c - 1;
        break;
      end
    end
    chk("search_finished", lat >= 0, 1);
  endtask

  // Scoreboard side: every done must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        logic [W:0] e;
        chk("busy_with_done", busy, 0);
        chk("done_single_cycle", prev_done, 0);
        chk("sb_pending_at_done", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("result", result, e[W-1:0]);
          chk("exact", exact, e[W]);
        end
      end
      prev_done <= done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    n_total = 0;
    n_bad   = 0;
    start = 1'b0; abort = 1'b0; tied = 1'b0; target = '0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_trial", trial, 0);
    chk("rst_result", result, 0);
    chk("rst_exact", exact, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Target 37: trial sequence, 6 busy cycles, early match at E6.
    run_one(6'd37, 1'b0, 6'd37, 1'b1, lat);
    exp_q = '{32, 48, 40, 36, 38, 37};
    chk_seq("trials_37");
    chk("lat_37", lat, 6);

    // Target 32: match on the very first decision edge.
    run_one(6'd32, 1'b0, 6'd32, 1'b1, lat);
    exp_q = '{32};
    chk_seq("trials_32");
    chk("lat_32", lat, 1);

    // Target 0: no early match, confirmed in CHK.
    run_one(6'd0, 1'b0, 6'd0, 1'b1, lat);
    exp_q = '{32, 16, 8, 4, 2, 1, 0};
    chk_seq("trials_0");
    chk("lat_0", lat, 7);

    // Comparator tied low: converges to all-ones, not exact.
    run_one(6'd5, 1'b1, 6'd63, 1'b0, lat);
    exp_q = '{32, 48, 56, 60, 62, 63, 63};
    chk_seq("trials_tied");
    chk("lat_tied", lat, 7);
    tied = 1'b0;

    // Exhaustive sweep, back-to-back starts, random start noise while busy.
    target = '0;
    sb.push_back({1'b1, 6'd0});
    @(negedge clk) start = 1'b1;
    for (int t = 0; t < 64; t++) begin
      int  c;
      logic got;
      got = 1'b0;
      @(posedge clk);
      #1 start = 1'($urandom_range(0, 1));
      for (c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (done) begin
          got = 1'b1;
          break;
        end
        start = 1'($urandom_range(0, 1));
      end
      chk("sweep_done_seen", got, 1);
      chk("sweep_latency_le7", (c - 1) <= 7, 1);
      if (t < 63) begin
        target = 6'(t + 1);
        sb.push_back({1'b1, 6'(t + 1)});
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    chk("sweep_sb_drained", sb.size(), 0);

    // Abort at E3 of a search for 37: no done, outputs frozen.
    target = 6'd37;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 63);
    chk("abort_exact", exact, 1);
    chk("abort_trial", trial, 40);
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", busy, 0);

    // Asynchronous reset between edges mid-search.
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_trial", trial, 0);
    chk("arst_result", result, 0);
    chk("arst_exact", exact, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_no_restart", busy, 0);

    // A fresh search after reset must start from the MSB again.
    run_one(6'd37, 1'b0, 6'd37, 1'b1, lat);
    exp_q = '{32, 48, 40, 36, 38, 37};
    chk_seq("trials_after_rst");

    repeat (2) @(negedge clk);
    chk("sb_empty_at_end", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
